// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the B-side APB wait-state register file.
// FSM state encoding, wait-field width and fixed register indices.
package apb_bridge_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam int WAIT_FLD_WD = 4;
    localparam int WAIT_REG    = 0;
    localparam int CTRL_REG    = 1;

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state down-counter: loaded at APB setup, decremented in access.
// zero flags that the access phase may complete this cycle.
module apb_wait_cnt
    import apb_bridge_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   dec,
    input  logic [WAIT_FLD_WD-1:0] load_val,
    output logic                   zero
);

    logic [WAIT_FLD_WD-1:0] cnt;

    // load wins over decrement; the two never coincide in practice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/apb_wait_regfile.sv
// APB completer with a small byte-strobed register bank and programmable
// wait states. Optional macro PROT_CHECK_EN blocks unprivileged accesses.
module apb_wait_regfile
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WD  = 32,
    parameter int DATA_WD  = 32,
    parameter int STRB_WD  = 4,
    parameter int PROT_WD  = 3,
    parameter int REG_NUM  = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic               b_pclk,
    input  logic               b_prst_n,
    input  logic               b_psel,
    input  logic               b_penable,
    input  logic               b_pwrite,
    input  logic [ADDR_WD-1:0] b_paddr,
    input  logic [DATA_WD-1:0] b_pwdata,
    input  logic [PROT_WD-1:0] b_pprot,
    input  logic [STRB_WD-1:0] b_pstrb,
    output logic [DATA_WD-1:0] b_prdata,
    output logic               b_pready,
    input  logic [DATA_WD-1:0] status_in,
    output logic [DATA_WD-1:0] ctrl_out
);

    localparam int IDX_WD   = $clog2(REG_NUM);
    localparam int STAT_IDX = REG_NUM - 1;
    localparam logic [DATA_WD-1:0] WORD0_RST = DATA_WD'(WAIT_CYC % 16);

    apb_state_t state_q;
    apb_state_t state_d;

    logic [IDX_WD-1:0]  idx;
    logic               in_range;
    logic               is_stat;
    logic               prot_ok;
    logic               cnt_zero;
    logic               cnt_load;
    logic               cnt_dec;
    logic               wr_en;
    logic [DATA_WD-1:0] rd_word;
    logic [DATA_WD-1:0] regs [STAT_IDX];
    logic               unused_ok;

    assign idx      = b_paddr[IDX_WD+1:2];
    assign in_range = ((b_paddr >> (IDX_WD + 2)) == '0);
    assign is_stat  = (idx == IDX_WD'(STAT_IDX));

`ifdef PROT_CHECK_EN
    assign prot_ok   = b_pprot[0];
    assign unused_ok = ^{b_pprot[PROT_WD-1:1], b_paddr[1:0]};
`else
    assign prot_ok   = 1'b1;
    assign unused_ok = ^{b_pprot, b_paddr[1:0]};
`endif

    assign cnt_load = (state_q == IDLE) & b_psel;
    assign cnt_dec  = (state_q == ACCESS) & b_psel & b_penable & ~cnt_zero;

    apb_wait_cnt u_wait_cnt (
        .clk      (b_pclk),
        .rst_n    (b_prst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (regs[WAIT_REG][WAIT_FLD_WD-1:0]),
        .zero     (cnt_zero)
    );

    assign b_pready = (state_q == ACCESS) & cnt_zero & b_psel & b_penable;

    assign wr_en = b_pready & b_pwrite & in_range & prot_ok & ~is_stat;

    // FSM state register
    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: any select in IDLE starts a transfer, drop or ready ends it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (b_psel) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!b_psel || b_pready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // register bank: byte-lane writes committed only on the completing edge
    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            for (int i = 0; i < STAT_IDX; i++) begin
                regs[i] <= (i == WAIT_REG) ? WORD0_RST : '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < STAT_IDX; i++) begin
                for (int b = 0; b < STRB_WD; b++) begin
                    if (idx == IDX_WD'(i) && b_pstrb[b]) begin
                        regs[i][8*b +: 8] <= b_pwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // read mux: top word is the live status input, out of range reads 0
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (is_stat) begin
                rd_word = status_in;
            end
            for (int i = 0; i < STAT_IDX; i++) begin
                if (idx == IDX_WD'(i)) begin
                    rd_word = regs[i];
                end
            end
        end
    end

    assign b_prdata = (b_pready & ~b_pwrite & prot_ok) ? rd_word : '0;
    assign ctrl_out = regs[CTRL_REG];

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Scoreboard bench for apb_wait_regfile: directed plan plus random traffic.
// Define PROT_CHECK_EN to also exercise the privilege filter.
module tb_apb_wait_regfile;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic [31:0] status;
    logic [31:0] ctrl;

    apb_wait_regfile dut (
        .b_pclk    (clk),
        .b_prst_n  (rst_n),
        .b_psel    (psel),
        .b_penable (penable),
        .b_pwrite  (pwrite),
        .b_paddr   (paddr),
        .b_pwdata  (pwdata),
        .b_pprot   (pprot),
        .b_pstrb   (pstrb),
        .b_prdata  (prdata),
        .b_pready  (pready),
        .status_in (status),
        .ctrl_out  (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        int          waits;
        string       name;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [16];
    int          checks   = 0;
    int          failures = 0;
    int          waits    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >> 6) == 0;
    endfunction

    function automatic bit prot_pass(input logic [2:0] p);
`ifdef PROT_CHECK_EN
        return p[0];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int i;
        if (!addr_ok(a)) return 32'h0;
        i = int'(a[5:2]);
        if (i == 15) return status;
        return mdl[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        mdl[0] = 32'd2;
    endtask

    // monitor: count stalled access cycles, pop and compare on completion
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            waits = 0;
        end else if (psel && penable) begin
            if (pready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pready actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_rdata"}, prdata, e.rdata);
                    chk({e.name, "_waits"}, waits, e.waits);
                end
                waits = 0;
            end else begin
                waits++;
            end
        end else begin
            waits = 0;
        end
    end

    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input bit illegal,
                        input string nm);
        exp_t e;
        int   n;
        bit   done;
        int   i;
        e.wr    = wr;
        e.name  = nm;
        e.waits = int'(mdl[0][3:0]) + (illegal ? 1 : 0);
        e.rdata = (!wr && prot_pass(p)) ? ref_read(a) : 32'h0;
        q.push_back(e);
        i = int'(a[5:2]);
        if (wr && prot_pass(p) && addr_ok(a) && i != 15) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = illegal; pwrite = wr;
        paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (pready) begin
                done = 1;
            end else begin
                n++;
                if (n > 40) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_timeout actual=no_pready required=pready", nm);
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string nm);
        xfer(1'b1, a, d, s, 3'b001, 1'b0, nm);
    endtask

    task automatic rd32(input logic [31:0] a, input string nm);
        xfer(1'b0, a, 32'h0, 4'h0, 3'b001, 1'b0, nm);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; pprot = 0; pstrb = 0;
        status = 32'hDEADBEEF;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_pready", {31'h0, pready}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_ctrl", ctrl, 32'h0);

        rd32(32'h00, "rd_wait_rst");
        wr32(32'h04, 32'hA5A5A5A5, 4'hF, "wr_ctrl");
        rd32(32'h04, "rd_ctrl");
        @(negedge clk);
        chk("ctrl_full", ctrl, 32'hA5A5A5A5);
        wr32(32'h04, 32'h11223344, 4'h5, "wr_ctrl_strb");
        rd32(32'h04, "rd_ctrl_strb");
        @(negedge clk);
        chk("ctrl_strb", ctrl, 32'hA522A544);

        wr32(32'h00, 32'h0, 4'hF, "wr_wait0");
        rd32(32'h04, "rd_wait0");
        wr32(32'h00, 32'h5, 4'hF, "wr_wait5");
        rd32(32'h04, "rd_wait5");

        rd32(32'h3C, "rd_stat");
        wr32(32'h3C, 32'h0, 4'hF, "wr_stat");
        rd32(32'h3C, "rd_stat2");
        rd32(32'h40, "rd_oor");
        wr32(32'h1000_0004, 32'hFFFFFFFF, 4'hF, "wr_oor");
        rd32(32'h07, "rd_ctrl_lowbits");
        wr32(32'h08, 32'h12345678, 4'h0, "wr_strb0");
        rd32(32'h08, "rd_strb0");
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, 1'b1, "rd_illegal");

        wr32(32'h00, 32'h4, 4'hF, "wr_wait4");
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h08; pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        rd32(32'h08, "rd_after_abort");

`ifdef PROT_CHECK_EN
        xfer(1'b1, 32'h08, 32'h1, 4'hF, 3'b000, 1'b0, "wr_unpriv");
        rd32(32'h08, "rd_after_unpriv");
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, "rd_unpriv");
        xfer(1'b1, 32'h08, 32'h1, 4'hF, 3'b001, 1'b0, "wr_priv");
        rd32(32'h08, "rd_after_priv");
`endif

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            logic [31:0] r;
            if ($urandom_range(0, 7) == 0) status = $urandom;
            r = $urandom;
            if ($urandom_range(0, 9) == 0) a = r;
            else a = ($urandom_range(0, 16) << 2) | (r & 32'h3);
            xfer(1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 1'b0, "rand");
        end
        @(negedge clk);
        chk("ctrl_rand", ctrl, mdl[1]);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h04; pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", {31'h0, pready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("midrst_ctrl", ctrl, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd32(32'(i * 4), "rd_after_rst");
        end

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_expect actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
